// File: rtl/priv_hpm_ctrl.sv
// Hardware performance monitor controller for mhpmcounter3..31.
// Maps per-cycle event strobes onto programmable 64-bit counters through
// per-counter event selectors, with enable gating, sticky overflow flags
// and the local counter-overflow interrupt request.
module priv_hpm_ctrl #(
  parameter int NUM_EVT   = 32,
  parameter int CTR_W     = 64,
  parameter int FIRST_CTR = 3,
  parameter int LAST_CTR  = 31
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_EVT-1:0] evt_in,
  input  logic               cfg_wen,
  input  logic [4:0]         cfg_idx,
  input  logic [4:0]         cfg_sel,
  input  logic               cfg_en,
  input  logic               cfg_ie,
  input  logic               ctr_wen,
  input  logic [4:0]         ctr_idx,
  input  logic [CTR_W-1:0]   ctr_wdata,
  input  logic [31:0]        ovf_clr,
  input  logic [4:0]         rd_idx,
  output logic [CTR_W-1:0]   rd_data,
  output logic [31:0]        ovf,
  output logic               lcofi
);

  // One bit per counter index that is actually implemented.
  function automatic logic [31:0] impl_mask_f();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i >= FIRST_CTR) && (i <= LAST_CTR);
    end
    return m;
  endfunction

  localparam logic [31:0]        IMPL_MASK = impl_mask_f();
  // Event 0 means "no event", so it is never captured.
  localparam logic [NUM_EVT-1:0] EVT_MASK  = ~{{(NUM_EVT-1){1'b0}}, 1'b1};
  localparam logic [CTR_W-1:0]   CTR_ONE   = {{(CTR_W-1){1'b0}}, 1'b1};

  logic [NUM_EVT-1:0] evt_q;
  logic [CTR_W-1:0]   ctr_q [32];
  logic [4:0]         sel_q [32];
  logic [31:0]        en_q;
  logic [31:0]        ie_q;
  logic [31:0]        ovf_q;

  logic [31:0]        inc;
  logic [31:0]        wr_hit;
  logic [31:0]        cfg_hit;
  logic [31:0]        ovf_set;

  // Stage-2 decode: per-counter increment, write/config hits and wrap detection.
  // A counter write suppresses the same-cycle increment, so it also cannot wrap.
  always_comb begin
    inc     = '0;
    wr_hit  = '0;
    cfg_hit = '0;
    ovf_set = '0;
    for (int i = 0; i < 32; i++) begin
      wr_hit[i]  = IMPL_MASK[i] && ctr_wen && (ctr_idx == i[4:0]);
      cfg_hit[i] = IMPL_MASK[i] && cfg_wen && (cfg_idx == i[4:0]);
      inc[i]     = IMPL_MASK[i] && en_q[i] && evt_q[sel_q[i]];
      ovf_set[i] = inc[i] && !wr_hit[i] && (&ctr_q[i]);
    end
  end

  // Event capture, configuration, counters and sticky overflow flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      evt_q <= '0;
      en_q  <= '0;
      ie_q  <= '0;
      ovf_q <= '0;
      for (int i = 0; i < 32; i++) begin
        ctr_q[i] <= '0;
        sel_q[i] <= '0;
      end
    end else begin
      evt_q <= evt_in & EVT_MASK;
      // A set in the same cycle as a clear leaves the flag set.
      ovf_q <= ((ovf_q & ~ovf_clr) | ovf_set) & IMPL_MASK;
      for (int i = 0; i < 32; i++) begin
        if (cfg_hit[i]) begin
          sel_q[i] <= cfg_sel;
          en_q[i]  <= cfg_en;
          ie_q[i]  <= cfg_ie;
        end
        if (wr_hit[i]) begin
          ctr_q[i] <= ctr_wdata;
        end else if (inc[i]) begin
          ctr_q[i] <= ctr_q[i] + CTR_ONE;
        end
      end
    end
  end

  // Combinational read, overflow view and interrupt request.
  always_comb begin
    rd_data = IMPL_MASK[rd_idx] ? ctr_q[rd_idx] : '0;
    ovf     = ovf_q & IMPL_MASK;
    lcofi   = |(ovf_q & ie_q & IMPL_MASK);
  end

endmodule

// File: doc/priv_hpm_ctrl.md
Name: priv_hpm_ctrl

Overview:
Hardware performance monitor controller for mhpmcounter3..31. It maps the raw per-cycle event strobes from the pipeline, caches and TLBs onto the programmable counters through per-counter event selectors, and applies enable and inhibit gating. It also owns the 64-bit counter storage, the sticky overflow flags and the local counter-overflow interrupt request. It sits inside the privileged unit, between the event-strobe assignments and the CSR file, which uses the config, write and read ports below.

Parameters:
NUM_EVT, 32, width of the event-strobe vector; event 0 is reserved as "no event".
CTR_W, 64, counter width in bits.
FIRST_CTR, 3, lowest implemented counter index.
LAST_CTR, 31, highest implemented counter index.

Ports:
CLK  in  1  clock.
RST  in  1  reset; asynchronous, active-high.
evt_in  in  NUM_EVT  raw event strobes, one cycle each; bit 0 is ignored.
cfg_wen  in  1  config write strobe.
cfg_idx  in  5  counter index for the config write.
cfg_sel  in  5  event select (index into evt_in).
cfg_en  in  1  counter enable.
cfg_ie  in  1  overflow interrupt enable.
ctr_wen  in  1  counter write strobe (CSR write to mhpmcounterN).
ctr_idx  in  5  counter index for the counter write.
ctr_wdata  in  CTR_W  counter write value.
ovf_clr  in  32  one-hot or multi-hot overflow-flag clear, one bit per index.
rd_idx  in  5  counter read index.
rd_data  out  CTR_W  counter value at rd_idx.
ovf  out  32  sticky overflow flags; bits outside FIRST_CTR..LAST_CTR are always 0.
lcofi  out  1  local counter-overflow interrupt request.

Behaviour:
- Reset (RST high, asynchronous):
  - sel, en, ie, all counters, ovf and the event pipeline register clear to 0.
  - Therefore rd_data=0, ovf=0, lcofi=0.
  - Reset asserted mid-operation discards any in-flight event.
- Pipeline, stage 1: evt_q <= evt_in & ~1, registered every cycle.
- Pipeline, stage 2: per implemented counter i, inc_i = en[i] & evt_q[sel[i]]; counter[i] <= counter[i] + inc_i.
- Latency: an event strobe at cycle N is visible on rd_data at cycle N+2.
- Config write: when cfg_wen is high and cfg_idx is in FIRST_CTR..LAST_CTR, sel/en/ie update at the clock edge. The new selection applies to the evt_q sample of the following cycle. Writes to any other index are ignored.
- Counter write: when ctr_wen is high and ctr_idx is valid, counter[ctr_idx] <= ctr_wdata.
  - A same-cycle increment of that counter is dropped; the write wins.
  - No overflow is generated by the write itself.
  - Writes to an invalid index are ignored.
- Wrap-around: when inc_i=1 and counter[i] is all-ones, counter[i] becomes 0 and ovf[i] is set. It stays set until cleared.
- Overflow clear: ovf_clr[i] clears ovf[i]. If an overflow set and a clear for the same bit occur in the same cycle, the set wins.
- lcofi is combinational: lcofi = |(ovf & ie).
- rd_data is combinational: rd_data = counter[rd_idx]; an invalid index returns 0.
- A read in the same cycle as a write to the same index returns the old value.
- Several counters may select the same event; each increments independently.
- sel=0 never increments.
- A disabled counter (en=0) holds its value but still accepts writes.
- A counter disabled mid-flight does not take an event already in evt_q: the enable is evaluated in stage 2, using the current en.

Test Plan:
- Reset and basic count: assert RST mid-count, then release. Configure idx 5 with sel=5, en=1. Pulse evt_in[5] for 3 cycles -> rd_data(5)=3 two cycles after the last pulse. ovf=0, lcofi=0.
- Wrap and interrupt: write counter[3]=64'hFFFF_FFFF_FFFF_FFFF with cfg sel=4, en=1, ie=1. Pulse evt_in[4] once -> counter[3]=0, ovf[3]=1, lcofi=1. Then pulse ovf_clr[3] -> ovf[3]=0, lcofi=0.
- Write versus increment collision: with counter[6]=10, a same-cycle ctr_wen (idx 6, wdata 100) and a stage-2 increment -> counter[6]=100, not 101.
- Set versus clear collision: an overflow event on counter 7 and ovf_clr[7] in the same cycle -> ovf[7]=1.
- Invalid index and shared events: a cfg write to idx 1 and a ctr write to idx 2 have no effect, and rd_data(1)=0. Counters 8 and 9 both with sel=13, en=1, plus 5 pulses of evt_in[13] -> both read 5.
- Disable and sel=0: with en[10]=0 and 4 pulses -> value unchanged. With sel=0, en=1 and evt_in=all-ones for 10 cycles -> no increment.
